// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide engine for the EX stage.
// Executes MULT, MULTU, DIV and DIVU one bit per cycle on operand
// magnitudes, then applies sign correction when the result is registered.
// The result is presented as a HI/LO pair for the HI/LO write-back path.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    input  logic             annul_i,
    output logic             busy_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             dbz_o
);

    // op_i encoding: bit 1 selects divide, bit 0 selects unsigned.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_is_div;
    logic                 r_neg_res;   // product / quotient must be negated
    logic                 r_neg_rem;   // remainder takes the dividend's sign
    logic [WIDTH-1:0]     r_a;         // multiplicand magnitude
    logic [WIDTH-1:0]     r_b;         // divisor magnitude
    logic [2*WIDTH-1:0]   r_acc;       // mul: {partial, multiplier}; div: {rem, quo}
    logic                 r_ready;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_dbz;

    logic                 w_signed_op;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_div_shift;
    logic                 w_div_ge;
    logic [WIDTH-1:0]     w_div_diff;
    logic [WIDTH-1:0]     w_div_rem;
    logic [2*WIDTH-1:0]   w_div_next;
    logic                 w_div_zero;
    logic [2*WIDTH-1:0]   w_prod_fin;
    logic [WIDTH-1:0]     w_quo_mag;
    logic [WIDTH-1:0]     w_rem_mag;
    logic [WIDTH-1:0]     w_quo_fin;
    logic [WIDTH-1:0]     w_rem_fin;

    // Operand magnitudes at issue; unsigned ops pass operands through.
    always_comb begin
        w_signed_op = ~op_i[0];
        w_abs_a     = (w_signed_op && opa_i[WIDTH-1]) ? -opa_i : opa_i;
        w_abs_b     = (w_signed_op && opb_i[WIDTH-1]) ? -opb_i : opb_i;
    end

    // One iteration of radix-2 shift-add multiply and restoring divide.
    always_comb begin
        // Multiply: add multiplicand into the upper half when the current
        // multiplier bit is set, then shift the whole accumulator right.
        w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
        w_mul_next  = {w_mul_sum, r_acc[WIDTH-1:1]};
        // Divide: shift the next dividend bit into the partial remainder and
        // subtract the divisor when it fits. The partial remainder is always
        // below the divisor, so the difference fits in WIDTH bits.
        w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_div_ge    = (w_div_shift >= {1'b0, r_b});
        w_div_diff  = w_div_shift[WIDTH-1:0] - r_b;
        w_div_rem   = w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
        w_div_next  = {w_div_rem, r_acc[WIDTH-2:0], w_div_ge};
        w_div_zero  = r_is_div && (r_b == '0);
    end

    // Sign correction applied to the finished magnitudes.
    always_comb begin
        w_prod_fin = r_neg_res ? -r_acc : r_acc;
        w_quo_mag  = r_acc[WIDTH-1:0];
        w_rem_mag  = r_acc[2*WIDTH-1:WIDTH];
        w_quo_fin  = r_neg_res ? -w_quo_mag : w_quo_mag;
        w_rem_fin  = r_neg_rem ? -w_rem_mag : w_rem_mag;
    end

    // Control FSM plus datapath and registered result outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: only control state and visible outputs are reset; the
            // datapath registers are always loaded at issue before being read.
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_dbz   <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i && !annul_i) begin
                        r_is_div  <= op_i[1];
                        r_a       <= w_abs_a;
                        r_b       <= w_abs_b;
                        r_neg_res <= w_signed_op && (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
                        r_neg_rem <= w_signed_op && opa_i[WIDTH-1];
                        r_acc     <= op_i[1] ? {{WIDTH{1'b0}}, w_abs_a}
                                             : {{WIDTH{1'b0}}, w_abs_b};
                        r_cnt     <= '0;
                        r_state   <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (annul_i) begin
                        r_state <= S_IDLE;
                    end else if (w_div_zero) begin
                        // Nothing to iterate; finish immediately.
                        r_state <= S_FIN;
                    end else begin
                        r_acc <= r_is_div ? w_div_next : w_mul_next;
                        if (r_cnt == LAST_ITER) begin
                            r_state <= S_FIN;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    if (!annul_i) begin
                        r_ready <= 1'b1;
                        if (w_div_zero) begin
                            r_hi  <= '0;
                            r_lo  <= '0;
                            r_dbz <= 1'b1;
                        end else if (r_is_div) begin
                            r_hi  <= w_rem_fin;
                            r_lo  <= w_quo_fin;
                            r_dbz <= 1'b0;
                        end else begin
                            r_hi  <= w_prod_fin[2*WIDTH-1:WIDTH];
                            r_lo  <= w_prod_fin[WIDTH-1:0];
                            r_dbz <= 1'b0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy_o  = (r_state == S_CALC);
    assign ready_o = r_ready;
    assign hi_o    = r_hi;
    assign lo_o    = r_lo;
    assign dbz_o   = r_dbz;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a 32-bit and an 8-bit instance share
// clock and reset; each step compares outputs against hand-computed values.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;

    logic        start32, annul32, busy32, rdy32, dbz32;
    logic [1:0]  op32;
    logic [31:0] a32, b32, hi32, lo32;

    logic        start8, annul8, busy8, rdy8, dbz8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, hi8, lo8;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    muldiv_unit #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .start_i(start32), .op_i(op32),
        .opa_i(a32), .opb_i(b32), .annul_i(annul32), .busy_o(busy32),
        .ready_o(rdy32), .hi_o(hi32), .lo_o(lo32), .dbz_o(dbz32)
    );

    muldiv_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start_i(start8), .op_i(op8),
        .opa_i(a8), .opb_i(b8), .annul_i(annul8), .busy_o(busy8),
        .ready_o(rdy8), .hi_o(hi8), .lo_o(lo8), .dbz_o(dbz8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation, then wait (bounded) for ready. lat counts clock
    // edges from the start edge to the edge that raised ready. poke_at >= 0
    // pulses a stray start on the 8-bit instance at that count.
    task automatic run_op(input bit w8, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int poke_at,
                          output int lat, output int busy_cnt);
        if (w8) begin
            start8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            start32 = 1'b1; op32 = op; a32 = a; b32 = b;
        end
        tick();
        start8 = 1'b0; start32 = 1'b0;
        // Scramble operands so only latched values can produce the result.
        op8 = OP_MULT; a8 = 8'h7F; b8 = 8'h7F;
        op32 = OP_MULT; a32 = 32'h1234_5678; b32 = 32'h0000_0003;
        lat = 0;
        busy_cnt = 0;
        while (!(w8 ? rdy8 : rdy32) && lat < 200) begin
            if (w8 ? busy8 : busy32) busy_cnt++;
            tick();
            lat++;
            if (w8) start8 = (lat == poke_at);
        end
        start8 = 1'b0;
    endtask

    initial begin
        int lat, bc, n;
        rst = 1'b0;
        start32 = 0; annul32 = 0; op32 = 0; a32 = 0; b32 = 0;
        start8 = 0; annul8 = 0; op8 = 0; a8 = 0; b8 = 0;
        tick();
        tick();

        // Reset state.
        check("rst_busy", busy32, 1'b0);
        check("rst_ready", rdy32, 1'b0);
        check("rst_hi", hi32, 32'h0);
        check("rst_lo", lo32, 32'h0);
        check("rst_dbz", dbz32, 1'b0);
        rst = 1'b1;
        tick();

        // MULTU all-ones squared, latency and busy length.
        run_op(0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, lat, bc);
        check("multu_lat", 64'(lat), 64'd33);
        check("multu_busy", 64'(bc), 64'd32);
        check("multu_hi", hi32, 32'hFFFF_FFFE);
        check("multu_lo", lo32, 32'h0000_0001);
        check("multu_dbz", dbz32, 1'b0);
        tick();
        check("ready_pulse", rdy32, 1'b0);

        // MULT -3*7, then DIVU 100/7 started in the ready cycle.
        run_op(0, OP_MULT, 32'hFFFF_FFFD, 32'd7, -1, lat, bc);
        check("mult_hi", hi32, 32'hFFFF_FFFF);
        check("mult_lo", lo32, 32'hFFFF_FFEB);
        run_op(0, OP_DIVU, 32'd100, 32'd7, -1, lat, bc);
        check("b2b_lat", 64'(lat), 64'd33);
        check("divu_lo", lo32, 32'h0000_000E);
        check("divu_hi", hi32, 32'h0000_0002);

        // Signed divide: truncation toward zero and MIN / -1 wrap.
        run_op(0, OP_DIV, 32'hFFFF_FFF9, 32'd2, -1, lat, bc);
        check("div_neg_lo", lo32, 32'hFFFF_FFFD);
        check("div_neg_hi", hi32, 32'hFFFF_FFFF);
        run_op(0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, lat, bc);
        check("div_ovf_lo", lo32, 32'h8000_0000);
        check("div_ovf_hi", hi32, 32'h0);
        check("div_ovf_dbz", dbz32, 1'b0);

        // Divide by zero, then a normal op clears the flag.
        run_op(0, OP_DIV, 32'd5, 32'd0, -1, lat, bc);
        check("dbz_lat", 64'(lat), 64'd2);
        check("dbz_flag", dbz32, 1'b1);
        check("dbz_hi", hi32, 32'h0);
        check("dbz_lo", lo32, 32'h0);
        run_op(0, OP_MULTU, 32'd2, 32'd3, -1, lat, bc);
        check("after_dbz_flag", dbz32, 1'b0);
        check("after_dbz_lo", lo32, 32'd6);
        check("after_dbz_hi", hi32, 32'd0);

        // Annul in CALC cycle 10: no ready, previous result held.
        start32 = 1'b1; op32 = OP_DIV; a32 = 32'd9; b32 = 32'd2;
        tick();
        start32 = 1'b0;
        repeat (9) tick();
        check("annul_in_calc", busy32, 1'b1);
        annul32 = 1'b1;
        tick();
        annul32 = 1'b0;
        check("annul_idle", busy32, 1'b0);
        n = 0;
        repeat (40) begin
            tick();
            if (rdy32) n++;
        end
        check("annul_no_ready", 64'(n), 64'd0);
        check("annul_hi", hi32, 32'd0);
        check("annul_lo", lo32, 32'd6);

        // start and annul together in IDLE: not accepted.
        start32 = 1'b1; annul32 = 1'b1; op32 = OP_MULTU; a32 = 32'd7; b32 = 32'd7;
        tick();
        start32 = 1'b0; annul32 = 1'b0;
        check("sa_not_busy", busy32, 1'b0);
        n = 0;
        repeat (40) begin
            tick();
            if (rdy32) n++;
        end
        check("sa_no_ready", 64'(n), 64'd0);
        check("sa_lo_held", lo32, 32'd6);

        // Reset mid-CALC clears all outputs on the next edge.
        start32 = 1'b1; op32 = OP_MULTU; a32 = 32'd5; b32 = 32'd5;
        tick();
        start32 = 1'b0;
        repeat (5) tick();
        check("pre_rst_busy", busy32, 1'b1);
        rst = 1'b0;
        tick();
        check("mid_rst_busy", busy32, 1'b0);
        check("mid_rst_ready", rdy32, 1'b0);
        check("mid_rst_hi", hi32, 32'h0);
        check("mid_rst_lo", lo32, 32'h0);
        check("mid_rst_dbz", dbz32, 1'b0);
        rst = 1'b1;
        n = 0;
        repeat (40) begin
            tick();
            if (rdy32) n++;
        end
        check("post_rst_no_ready", 64'(n), 64'd0);

        // 8-bit instance.
        run_op(1, OP_MULT, 32'h80, 32'h80, -1, lat, bc);
        check("w8_mult_lat", 64'(lat), 64'd9);
        check("w8_mult_busy", 64'(bc), 64'd8);
        check("w8_mult_hi", hi8, 8'h40);
        check("w8_mult_lo", lo8, 8'h00);
        run_op(1, OP_DIV, 32'h80, 32'hFF, -1, lat, bc);
        check("w8_div_lo", lo8, 8'h80);
        check("w8_div_hi", hi8, 8'h00);
        run_op(1, OP_MULTU, 32'hFF, 32'hFF, -1, lat, bc);
        check("w8_multu_hi", hi8, 8'hFE);
        check("w8_multu_lo", lo8, 8'h01);
        run_op(1, OP_MULTU, 32'h0F, 32'h11, 3, lat, bc);
        check("w8_poke_lat", 64'(lat), 64'd9);
        check("w8_poke_hi", hi8, 8'h00);
        check("w8_poke_lo", lo8, 8'hFF);
        n = 0;
        repeat (20) begin
            tick();
            if (rdy8) n++;
        end
        check("w8_poke_no_extra", 64'(n), 64'd0);
        run_op(1, OP_DIVU, 32'd13, 32'd4, -1, lat, bc);
        check("w8_divu_lo", lo8, 8'd3);
        check("w8_divu_hi", hi8, 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide engine for the EX stage, next generation of the current divide-only path. One unit executes MULT, MULTU, DIV and DIVU. It uses a start/ready handshake and an annul input, and presents a HI/LO result pair for the HI/LO write-back path. The hazard unit stalls on busy_o.

Parameters:
WIDTH, 32, operand width; hi_o and lo_o are each WIDTH bits; product is 2*WIDTH bits.
CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-low (rst=0 resets on the clock edge)
start_i  in  1  request a new operation; sampled only in IDLE
op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start_i
opa_i  in  WIDTH  multiplicand / dividend
opb_i  in  WIDTH  multiplier / divisor
annul_i  in  1  abort current operation
busy_o  out  1  high while in CALC
ready_o  out  1  one-cycle pulse; hi_o/lo_o are valid from this cycle onward
hi_o  out  WIDTH  product high half / remainder
lo_o  out  WIDTH  product low half / quotient
dbz_o  out  1  divide-by-zero flag for the last completed operation

Behaviour:
- Reset (rst=0 at an edge):
  - state goes to IDLE.
  - busy_o=0, ready_o=0, hi_o=0, lo_o=0, dbz_o=0.
  - Applies in any state; an in-flight operation is discarded with no ready pulse.
- FSM states: IDLE, CALC, FIN.
- IDLE, on start_i=1 and annul_i=0:
  - Latch op_i, |opa_i| and |opb_i|. Absolute values apply only for signed ops; unsigned ops latch operands unchanged.
  - Latch the sign information.
  - Clear the counter; go to CALC.
- Divide by zero: DIV/DIVU with opb_i==0 goes directly to FIN.
  - FIN then gives hi_o=0, lo_o=0, dbz_o=1.
  - ready_o pulses 2 cycles after the start edge.
- CALC:
  - Executes one bit per cycle for exactly WIDTH cycles, then goes to FIN.
  - Multiply: radix-2 shift-add into a 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle.
- FIN:
  - Apply sign correction and register the results.
  - Multiply: product negated if sign(a) XOR sign(b) for MULT. {hi_o,lo_o} = product.
  - Divide: lo_o = quotient, negated if signs differ (DIV). hi_o = remainder, carrying the sign of the dividend (DIV).
  - Division truncates toward zero.
  - dbz_o=0 for non-zero divisors; ready_o=1 for this cycle only; next state IDLE.
- Latency: start sampled at edge N; ready_o high in cycle N+WIDTH+1.
  - Back-to-back: a new start is accepted in the IDLE cycle right after FIN.
- Results: hi_o, lo_o and dbz_o hold their values until the next FIN or reset. They are not changed by annul or by ignored starts.
- start_i while in CALC or FIN is ignored; the requester must hold or re-issue it.
- annul_i=1 in CALC or FIN:
  - Next state is IDLE; no ready pulse; outputs are unchanged.
  - annul_i in FIN also suppresses the register update.
- annul_i and start_i together in IDLE: annul wins and the start is not accepted.
- Overflow cases wrap and raise no exception:
  - Signed MIN / -1 gives lo_o=MIN, hi_o=0.
  - MIN*MIN gives the exact 2*WIDTH product.
- busy_o is registered state decode (state==CALC), so the hazard unit sees no combinational path from start_i.

Test Plan:
- MULTU, WIDTH=32, 0xFFFFFFFF*0xFFFFFFFF -> hi_o=0xFFFFFFFE, lo_o=0x00000001. ready_o pulses exactly 33 cycles after the start edge; busy_o is high for 32 cycles.
- MULT -3*7 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFEB. Then a back-to-back DIVU 100/7 started in the following IDLE cycle -> lo_o=0x0000000E, hi_o=0x00000002.
- DIV -7/2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo_o=0x80000000, hi_o=0, dbz_o=0.
- DIV 5/0 -> ready_o 2 cycles after start, dbz_o=1, hi_o=lo_o=0. A following MULTU 2*3 -> dbz_o=0, lo_o=6.
- Annul and reset:
  - Complete MULTU 2*3, then start DIV 9/2 and assert annul_i in CALC cycle 10 -> no ready_o, hi_o=0, lo_o=6 held.
  - start_i+annul_i together in IDLE -> not accepted.
  - rst=0 mid-CALC -> all outputs 0 on the next edge.
- WIDTH=8 instance:
  - MULT 0x80*0x80 -> hi_o=0x40, lo_o=0x00, ready_o after 9 cycles.
  - DIV 0x80/0xFF -> lo_o=0x80, hi_o=0x00.
  - start_i pulsed during CALC -> ignored, result unaffected.
